// File: rtl/hex_cmd_assembler_if.sv
// Keypad command stream bundle: UART RX bytes in, committed value out.
// master drives rx_data/rx_valid; slave (assembler) drives the results.
interface hex_cmd_assembler_if #(
  parameter int DIGITS = 4
);
  localparam int CW = $clog2(DIGITS + 1);

  logic [7:0]          rx_data;
  logic                rx_valid;
  logic [4*DIGITS-1:0] value;
  logic                value_valid;
  logic [CW-1:0]       digit_count;
  logic                err;

  modport master (
    output rx_data, rx_valid,
    input  value, value_valid, digit_count, err
  );

  modport slave (
    input  rx_data, rx_valid,
    output value, value_valid, digit_count, err
  );
endinterface

// File: rtl/hex_cmd_assembler.sv
// Keypad-ASCII command assembler: digits shift into a word, '#' commits,
// '*' cancels. Ports: clk, rst_n (sync, active-low), bus (slave modport:
// rx_data/rx_valid in; value/value_valid/digit_count/err out).
// Optional macro LOWERCASE_HEX_EN: accept 'a'-'d' as digits 10-13.
module hex_cmd_assembler #(
  parameter int DIGITS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  hex_cmd_assembler_if.slave   bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    OVF
  } state_t;

  state_t         st, st_n;
  logic [W-1:0]   acc, acc_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [W-1:0]   val, val_n;
  logic           vv, vv_n;
  logic           er, er_n;

  logic           is_dig, is_clr, is_ent, is_oth;
  logic [3:0]     nib;
  logic [7:0]     d;

  assign d = bus.rx_data;

  // Character classifier; classes are mutually exclusive.
  always_comb begin
    is_dig = 1'b0;
    nib    = 4'd0;
    if (d >= 8'h30 && d <= 8'h39) begin
      is_dig = 1'b1;
      nib    = d[3:0];
    end else if (d >= 8'h41 && d <= 8'h44) begin
      is_dig = 1'b1;
      nib    = d[3:0] + 4'd9;
    end
`ifdef LOWERCASE_HEX_EN
    else if (d >= 8'h61 && d <= 8'h64) begin
      is_dig = 1'b1;
      nib    = d[3:0] + 4'd9;
    end
`endif
    is_clr = (d == 8'h2A);
    is_ent = (d == 8'h23);
    is_oth = !(is_dig || is_clr || is_ent);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= IDLE;
      acc <= '0;
      cnt <= '0;
      val <= '0;
      vv  <= 1'b0;
      er  <= 1'b0;
    end else begin
      st  <= st_n;
      acc <= acc_n;
      cnt <= cnt_n;
      val <= val_n;
      vv  <= vv_n;
      er  <= er_n;
    end
  end

  always_comb begin
    st_n  = st;
    acc_n = acc;
    cnt_n = cnt;
    val_n = val;
    vv_n  = 1'b0;
    er_n  = 1'b0;
    if (bus.rx_valid) begin
      unique case (1'b1)
        is_clr: begin
          st_n  = IDLE;
          acc_n = '0;
          cnt_n = '0;
        end
        is_ent: begin
          st_n  = IDLE;
          acc_n = '0;
          cnt_n = '0;
          if (st == COLLECT) begin
            val_n = acc;
            vv_n  = 1'b1;
          end else begin
            er_n  = 1'b1;
          end
        end
        is_dig: begin
          unique case (st)
            IDLE: begin
              acc_n = W'(nib);
              cnt_n = CW'(1);
              st_n  = COLLECT;
            end
            COLLECT: begin
              if (cnt < CW'(DIGITS)) begin
                acc_n = (acc << 4) | W'(nib);
                cnt_n = cnt + CW'(1);
              end else begin
                // Overflow: freeze acc/count until a terminator.
                er_n = 1'b1;
                st_n = OVF;
              end
            end
            default: begin
            end
          endcase
        end
        is_oth: begin
          st_n  = IDLE;
          acc_n = '0;
          cnt_n = '0;
          er_n  = 1'b1;
        end
      endcase
    end
  end

  assign bus.value       = val;
  assign bus.value_valid = vv;
  assign bus.digit_count = cnt;
  assign bus.err         = er;
endmodule
